// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and line levels, common to the tx and rx paths.
package uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t START  = 3'd1;
    localparam state_t DATA   = 3'd2;
    localparam state_t PARITY = 3'd3;
    localparam state_t STOP   = 3'd4;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/baud_gen_tx.sv
// Bit-rate tick generator for the tx path; i_rst is a synchronous restart so a frame can
// re-align bit timing to its start bit. o_baud_en is registered, one clock per MAX_CNT clocks.
module baud_gen_tx #(
    parameter int CLK_FREQ  = 16,
    parameter int BAUD_RATE = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_baud_en
);
    localparam int MAX_CNT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W   = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_baud_en;
    logic             w_wrap;

    assign w_wrap    = (r_cnt == CNT_W'(MAX_CNT - 1));
    assign o_baud_en = r_baud_en;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_baud_en <= 1'b0;
        end else begin
            r_cnt     <= w_wrap ? '0 : r_cnt + CNT_W'(1);
            r_baud_en <= w_wrap;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, data LSB first, optional parity, stop bits.
// Bits advance on qualified ticks from baud_gen_tx, which is restarted at every accept.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    input  logic                 i_baud_en,
    output logic                 o_baud_rst,
    output logic                 o_txd,
    output logic                 o_tx_busy,
    output logic                 o_tx_done
);
    localparam int CNT_W = $clog2(DATA_BITS + 1);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
            $error("uart_tx_ctrl: DATA_BITS must be in 5..8");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
        end
    endgenerate

    state_t               r_state, w_state_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 r_parity;
    logic                 r_txd, r_tx_ready, r_tx_busy, r_tx_done, r_baud_rst;
    logic                 w_accept, w_tick, w_last_data, w_last_stop, w_txd_nxt;

    assign w_accept    = i_tx_valid & r_tx_ready;
    // Ticks in IDLE or in the restart cycle are left over from the previous bit period.
    assign w_tick      = i_baud_en & ~r_baud_rst & (r_state != IDLE);
    assign w_last_data = (r_bit_cnt == CNT_W'(DATA_BITS - 1));
    assign w_last_stop = (r_stop_cnt == 1'(STOP_BITS - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)                w_state_nxt = START;
            START:   if (w_tick)                  w_state_nxt = DATA;
            DATA:    if (w_tick && w_last_data)   w_state_nxt = PARITY_EN ? PARITY : STOP;
            PARITY:  if (w_tick)                  w_state_nxt = STOP;
            STOP:    if (w_tick && w_last_stop)   w_state_nxt = IDLE;
            default:                              w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_shift_nxt = r_shift;
        if (w_accept)                       w_shift_nxt = i_tx_data;
        else if (w_tick && r_state == DATA) w_shift_nxt = r_shift >> 1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_parity   <= 1'b0;
        end else begin
            r_shift <= w_shift_nxt;
            if (w_accept) begin
                r_bit_cnt  <= '0;
                r_stop_cnt <= 1'b0;
                r_parity   <= (^i_tx_data) ^ PARITY_ODD;
            end else if (w_tick) begin
                if (r_state == DATA && !w_last_data) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                if (r_state == STOP)                 r_stop_cnt <= ~r_stop_cnt;
            end
        end
    end

    // Line level is decided from the next state so TXD moves the cycle after the tick.
    always_comb begin
        w_txd_nxt = LINE_IDLE;
        case (w_state_nxt)
            START:   w_txd_nxt = LINE_START;
            DATA:    w_txd_nxt = w_shift_nxt[0];
            PARITY:  w_txd_nxt = r_parity;
            default: w_txd_nxt = LINE_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_txd      <= LINE_IDLE;
            r_tx_ready <= 1'b0;
            r_tx_busy  <= 1'b0;
            r_tx_done  <= 1'b0;
            r_baud_rst <= 1'b0;
        end else begin
            r_txd      <= w_txd_nxt;
            r_tx_ready <= (w_state_nxt == IDLE);
            r_tx_busy  <= (w_state_nxt != IDLE);
            r_tx_done  <= (r_state == STOP) && (w_state_nxt == IDLE);
            r_baud_rst <= w_accept;
        end
    end

    assign o_txd      = r_txd;
    assign o_tx_ready = r_tx_ready;
    assign o_tx_busy  = r_tx_busy;
    assign o_tx_done  = r_tx_done;
    assign o_baud_rst = r_baud_rst;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: five parameter variants, each paired with its own baud_gen_tx (MAX_CNT=16).
module tb_uart_tx_ctrl;
    localparam int N = 5;
    localparam int DB [N] = '{8, 8, 8, 8, 7};
    localparam int PE [N] = '{0, 1, 1, 0, 1};
    localparam int PO [N] = '{0, 0, 1, 0, 1};
    localparam int SB [N] = '{1, 1, 1, 2, 2};

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] vld   = '0;
    logic [N-1:0] frc   = '0;
    logic [7:0]   dat [N];
    wire  [N-1:0] rdy, brst, bgen, txd, busy, done;
    wire  [N-1:0] ben = bgen | frc;
    int           n_chk = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_bg
        baud_gen_tx #(.CLK_FREQ(16), .BAUD_RATE(1)) u_bg (
            .i_clk(clk), .i_rst(brst[g] | ~rst_n), .o_baud_en(bgen[g]));
    end

    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(dat[0]), .i_tx_valid(vld[0]), .o_tx_ready(rdy[0]),
        .i_baud_en(ben[0]), .o_baud_rst(brst[0]), .o_txd(txd[0]), .o_tx_busy(busy[0]), .o_tx_done(done[0]));
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(dat[1]), .i_tx_valid(vld[1]), .o_tx_ready(rdy[1]),
        .i_baud_en(ben[1]), .o_baud_rst(brst[1]), .o_txd(txd[1]), .o_tx_busy(busy[1]), .o_tx_done(done[1]));
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(dat[2]), .i_tx_valid(vld[2]), .o_tx_ready(rdy[2]),
        .i_baud_en(ben[2]), .o_baud_rst(brst[2]), .o_txd(txd[2]), .o_tx_busy(busy[2]), .o_tx_done(done[2]));
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(dat[3]), .i_tx_valid(vld[3]), .o_tx_ready(rdy[3]),
        .i_baud_en(ben[3]), .o_baud_rst(brst[3]), .o_txd(txd[3]), .o_tx_busy(busy[3]), .o_tx_done(done[3]));
    uart_tx_ctrl #(.DATA_BITS(7), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(2)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(dat[4][6:0]), .i_tx_valid(vld[4]), .o_tx_ready(rdy[4]),
        .i_baud_en(ben[4]), .o_baud_rst(brst[4]), .o_txd(txd[4]), .o_tx_busy(busy[4]), .o_tx_done(done[4]));

    // Reference: the frame as a list of line levels; start bit 18 clk, all others 16 clk.
    task automatic check_frame(input int idx, input logic [7:0] data, input string nm);
        logic exp_q[$];
        logic par;
        int   dur, good, dn, bz;
        exp_q.push_back(1'b0);
        par = (PO[idx] != 0);
        for (int i = 0; i < DB[idx]; i++) begin
            exp_q.push_back(data[i]);
            par ^= data[i];
        end
        if (PE[idx] != 0) exp_q.push_back(par);
        for (int s = 0; s < SB[idx]; s++) exp_q.push_back(1'b1);

        n_chk++;
        if ({busy[idx], rdy[idx], brst[idx], txd[idx]} !== 4'b1010) begin
            n_fail++;
            $display("FAIL %s accept: busy/ready/baud_rst/txd=%b, required 1010", nm,
                     {busy[idx], rdy[idx], brst[idx], txd[idx]});
        end
        dn = 0;
        bz = 0;
        foreach (exp_q[b]) begin
            dur  = (b == 0) ? 18 : 16;
            good = 0;
            for (int c = 0; c < dur; c++) begin
                if (b != 0 || c != 0) begin
                    @(posedge clk);
                    #1;
                end
                if (txd[idx] === exp_q[b]) good++;
                if (done[idx] !== 1'b0) dn++;
                if (busy[idx] !== 1'b1) bz++;
                if (b == 0 && c == 1) begin
                    n_chk++;
                    if (brst[idx] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s baud_rst_width: baud_rst=%b in 2nd cycle, required 0", nm, brst[idx]);
                    end
                end
            end
            n_chk++;
            if (good != dur) begin
                n_fail++;
                $display("FAIL %s bit%0d: txd at level %b for %0d of %0d clk, required all %0d",
                         nm, b, exp_q[b], good, dur, dur);
            end
        end
        n_chk++;
        if (dn != 0 || bz != 0) begin
            n_fail++;
            $display("FAIL %s in_frame: done high %0d clk, busy low %0d clk, required 0 and 0", nm, dn, bz);
        end
        @(posedge clk);
        #1;
        n_chk++;
        if ({done[idx], busy[idx], rdy[idx], txd[idx]} !== 4'b1011) begin
            n_fail++;
            $display("FAIL %s end: done/busy/ready/txd=%b, required 1011", nm,
                     {done[idx], busy[idx], rdy[idx], txd[idx]});
        end
    endtask

    task automatic accept(input int idx, input logic [7:0] data);
        int w = 0;
        while (rdy[idx] !== 1'b1 && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        n_chk++;
        if (rdy[idx] !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_wait%0d: tx_ready=%b after %0d clk, required 1", idx, rdy[idx], w);
        end
        dat[idx] = data;
        vld[idx] = 1'b1;
        @(posedge clk);
        #1;
        vld[idx] = 1'b0;
        dat[idx] = 8'($urandom);
    endtask

    task automatic send(input int idx, input logic [7:0] data, input string nm);
        accept(idx, data);
        check_frame(idx, data, nm);
    endtask

    task automatic test_reset();
        #12;
        n_chk++;
        if ({txd, rdy, busy, done, brst} !== {{N{1'b1}}, {(4*N){1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_state: txd=%b ready=%b busy=%b done=%b baud_rst=%b, required all-1/0/0/0/0",
                     txd, rdy, busy, done, brst);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_chk++;
        if (rdy !== '0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b before first edge, required 0", rdy);
        end
        @(posedge clk);
        #1;
        n_chk++;
        if (rdy !== {N{1'b1}}) begin
            n_fail++;
            $display("FAIL reset_ready: ready=%b after first edge, required all 1", rdy);
        end
    endtask

    task automatic test_basic();
        send(0, 8'h55, "8n1_55");
        repeat (3) send(0, 8'($urandom), "8n1_rand");
    endtask

    task automatic test_parity();
        send(1, 8'hA3, "8e1_a3");
        send(2, 8'hA3, "8o1_a3");
        repeat (2) begin
            send(1, 8'($urandom), "8e1_rand");
            send(2, 8'($urandom), "8o1_rand");
        end
    endtask

    task automatic test_stop_bits();
        send(3, 8'h00, "8n2_00");
        send(3, 8'($urandom), "8n2_rand");
        send(4, 8'($urandom), "7o2_rand");
        send(4, 8'h7F, "7o2_7f");
    endtask

    task automatic test_back_to_back();
        accept(0, 8'h01);
        vld[0] = 1'b1;
        dat[0] = 8'hFF;
        check_frame(0, 8'h01, "b2b_first");
        @(posedge clk);
        #1;
        vld[0] = 1'b0;
        dat[0] = 8'($urandom);
        check_frame(0, 8'hFF, "b2b_second");
    endtask

    task automatic test_stale_tick();
        logic [7:0] d;
        int good = 0;
        frc[0] = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (txd[0] === 1'b1 && busy[0] === 1'b0 && rdy[0] === 1'b1) good++;
        end
        frc[0] = 1'b0;
        n_chk++;
        if (good != 20) begin
            n_fail++;
            $display("FAIL stale_idle: idle held for %0d of 20 clk with forced tick, required 20", good);
        end
        d = 8'($urandom);
        accept(0, d);
        frc[0] = 1'b1;
        fork
            check_frame(0, d, "stale_rst_cycle");
            begin
                @(posedge clk);
                #1;
                frc[0] = 1'b0;
            end
        join
    endtask

    task automatic test_reset_mid();
        int dn = 0;
        int hi = 0;
        accept(0, 8'($urandom));
        repeat (18 + 16 * 3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({txd[0], busy[0], rdy[0]} !== 3'b100) begin
            n_fail++;
            $display("FAIL mid_reset_async: txd/busy/ready=%b, required 100", {txd[0], busy[0], rdy[0]});
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done[0] !== 1'b0) dn++;
            if (txd[0] === 1'b1) hi++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        if (done[0] !== 1'b0) dn++;
        n_chk++;
        if (dn != 0 || hi != 3) begin
            n_fail++;
            $display("FAIL mid_reset_hold: done pulses %0d, txd high %0d of 3 clk, required 0 and 3", dn, hi);
        end
        n_chk++;
        if (rdy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_ready: ready=%b after release edge, required 1", rdy[0]);
        end
        send(0, 8'($urandom), "after_reset");
    endtask

    initial begin
        for (int i = 0; i < N; i++) dat[i] = 8'h00;
        test_reset();
        test_basic();
        test_parity();
        test_stop_bits();
        test_back_to_back();
        test_stale_tick();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
